// File: rtl/fetch_controller_if.sv
// Bundle between the fetch sequencer and its neighbours (hazard unit, branch resolution, Fetch).
// master = fetch_controller side, slave = the surrounding pipeline.
interface fetch_controller_if #(
  parameter int PC_WIDTH          = 32,
  parameter int INSTRUCTION_WIDTH = 32,
  parameter int COUNT_WIDTH       = 16
);
  logic                         start;
  logic                         stall;
  logic                         redirectValid;
  logic [PC_WIDTH-1:0]          redirectPC;
  logic [INSTRUCTION_WIDTH-1:0] instruction;
  logic                         fetchEnable;
  logic                         PCSelector;
  logic [PC_WIDTH-1:0]          NewPC;
  logic                         flush;
  logic                         running;
  logic                         halted;
  logic [COUNT_WIDTH-1:0]       fetchedCount;

  modport master (
    input  start, stall, redirectValid, redirectPC, instruction,
    output fetchEnable, PCSelector, NewPC, flush, running, halted, fetchedCount
  );

  modport slave (
    output start, stall, redirectValid, redirectPC, instruction,
    input  fetchEnable, PCSelector, NewPC, flush, running, halted, fetchedCount
  );
endinterface

// File: rtl/fetch_controller.sv
// Fetch-stage sequencer: starts the program, applies stalls and branch redirects,
// and drains the pipeline on HALT before parking. Sole writer of the PC.
module fetch_controller #(
  parameter int                      PC_WIDTH          = 32,
  parameter int                      INSTRUCTION_WIDTH = 32,
  parameter int                      OPCODE_WIDTH      = 4,
  parameter logic [OPCODE_WIDTH-1:0] HALT_OPCODE       = 4'hF,
  parameter logic [PC_WIDTH-1:0]     RESET_VECTOR      = '0,
  parameter int                      DRAIN_CYCLES      = 4,
  parameter int                      COUNT_WIDTH       = 16
) (
  input logic                clock,
  input logic                reset,
  fetch_controller_if.master bus
);

  localparam int DRAIN_WIDTH = $clog2(DRAIN_CYCLES + 1);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, HALTED} state_t;

  state_t                   state_q, state_d;
  logic [DRAIN_WIDTH-1:0]   drain_cnt_q, drain_cnt_d;
  logic [COUNT_WIDTH-1:0]   count_q, count_d;
  logic                     fetch_enable, pc_select, flush, count_inc;
  logic [PC_WIDTH-1:0]      new_pc;
  logic [OPCODE_WIDTH-1:0]  opcode;

  assign opcode = bus.instruction[INSTRUCTION_WIDTH-1 -: OPCODE_WIDTH];

  always_comb begin
    state_d      = state_q;
    drain_cnt_d  = drain_cnt_q;
    count_d      = count_q;
    fetch_enable = 1'b0;
    pc_select    = 1'b0;
    new_pc       = '0;
    flush        = 1'b0;
    count_inc    = 1'b0;

    case (state_q)
      IDLE, HALTED: begin
        if (bus.start) begin
          fetch_enable = 1'b1;
          pc_select    = 1'b1;
          new_pc       = RESET_VECTOR;
          flush        = 1'b1;
          count_d      = '0;
          state_d      = RUN;
        end
      end
      RUN: begin
        if (bus.redirectValid) begin
          fetch_enable = 1'b1;
          pc_select    = 1'b1;
          new_pc       = bus.redirectPC;
          flush        = 1'b1;
          count_inc    = 1'b1;
        end else if (opcode == HALT_OPCODE && !bus.stall) begin
          flush       = 1'b1;
          drain_cnt_d = DRAIN_WIDTH'(DRAIN_CYCLES);
          state_d     = DRAIN;
        end else if (!bus.stall) begin
          fetch_enable = 1'b1;
          count_inc    = 1'b1;
        end
      end
      DRAIN: begin
        // flush stays high so the held HALT word never reaches decode twice
        flush = 1'b1;
        if (bus.redirectValid) begin
          fetch_enable = 1'b1;
          pc_select    = 1'b1;
          new_pc       = bus.redirectPC;
          state_d      = RUN;
        end else begin
          drain_cnt_d = drain_cnt_q - 1'b1;
          if (drain_cnt_q == DRAIN_WIDTH'(1)) state_d = HALTED;
        end
      end
      default: state_d = IDLE;
    endcase

    if (count_inc && count_q != '1) count_d = count_q + 1'b1;

    if (!reset) begin
      fetch_enable = 1'b0;
      pc_select    = 1'b0;
      new_pc       = '0;
      flush        = 1'b0;
    end
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q     <= IDLE;
      drain_cnt_q <= '0;
      count_q     <= '0;
    end else begin
      state_q     <= state_d;
      drain_cnt_q <= drain_cnt_d;
      count_q     <= count_d;
    end
  end

  assign bus.fetchEnable  = fetch_enable;
  assign bus.PCSelector   = pc_select;
  assign bus.NewPC        = new_pc;
  assign bus.flush        = flush;
  assign bus.running      = (state_q == RUN);
  assign bus.halted       = (state_q == HALTED);
  assign bus.fetchedCount = count_q;

endmodule

// File: tb/tb_fetch_controller.sv
// Bench for fetch_controller: a vector table of inputs with hand-derived expectations,
// plus a 2-bit-counter instance sharing the same stimulus to exercise saturation.
module tb_fetch_controller;

  localparam logic [31:0] NOP = 32'h0000_0001;
  localparam logic [31:0] HLT = 32'hF000_0000;

  typedef struct {
    logic        rst_n, start, stall, redir;
    logic [31:0] rpc, instr;
    logic        fe, sel;
    logic [31:0] npc;
    logic        fl;
    logic        run, halt, chk_cnt;
    logic [15:0] cnt;
    logic [1:0]  cnt_s;
  } vec_t;

  logic        clock = 1'b0;
  logic        reset;
  logic        start, stall, redirect_valid;
  logic [31:0] redirect_pc, instruction;
  int          checks = 0;
  int          errors = 0;
  vec_t        tbl[$];
  vec_t        sb[$];

  always #5 clock = ~clock;

  fetch_controller_if #(.PC_WIDTH(32), .INSTRUCTION_WIDTH(32), .COUNT_WIDTH(16)) bus ();
  fetch_controller_if #(.PC_WIDTH(32), .INSTRUCTION_WIDTH(32), .COUNT_WIDTH(2))  bus_s ();

  assign bus.start           = start;
  assign bus.stall           = stall;
  assign bus.redirectValid   = redirect_valid;
  assign bus.redirectPC      = redirect_pc;
  assign bus.instruction     = instruction;
  assign bus_s.start         = start;
  assign bus_s.stall         = stall;
  assign bus_s.redirectValid = redirect_valid;
  assign bus_s.redirectPC    = redirect_pc;
  assign bus_s.instruction   = instruction;

  fetch_controller #(.DRAIN_CYCLES(4), .COUNT_WIDTH(16)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  fetch_controller #(.DRAIN_CYCLES(4), .COUNT_WIDTH(2)) dut_s (
    .clock (clock),
    .reset (reset),
    .bus   (bus_s)
  );

  function automatic vec_t mk(logic rst_n, logic st, logic sl, logic rd, logic [31:0] rpc,
                              logic [31:0] ins, logic fe, logic sel, logic [31:0] npc, logic fl,
                              logic run, logic halt, logic chk, logic [15:0] cnt, logic [1:0] cs);
    vec_t v;
    v.rst_n = rst_n; v.start = st; v.stall = sl; v.redir = rd; v.rpc = rpc; v.instr = ins;
    v.fe = fe; v.sel = sel; v.npc = npc; v.fl = fl;
    v.run = run; v.halt = halt; v.chk_cnt = chk; v.cnt = cnt; v.cnt_s = cs;
    return v;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Registered results of the previous vector are checked once its edge has passed.
  task automatic checkRegistered();
    vec_t e;
    if (sb.size() == 0) return;
    e = sb.pop_front();
    checkOutput("running", 32'(bus.running), 32'(e.run));
    checkOutput("halted", 32'(bus.halted), 32'(e.halt));
    checkOutput("running_s", 32'(bus_s.running), 32'(e.run));
    if (e.chk_cnt) begin
      checkOutput("fetchedCount", 32'(bus.fetchedCount), 32'(e.cnt));
      checkOutput("fetchedCount_sat", 32'(bus_s.fetchedCount), 32'(e.cnt_s));
    end
  endtask

  task automatic applyStimulus(input vec_t v);
    @(negedge clock);
    checkRegistered();
    reset          = v.rst_n;
    start          = v.start;
    stall          = v.stall;
    redirect_valid = v.redir;
    redirect_pc    = v.rpc;
    instruction    = v.instr;
    sb.push_back(v);
    #2;
    checkOutput("fetchEnable", 32'(bus.fetchEnable), 32'(v.fe));
    checkOutput("PCSelector", 32'(bus.PCSelector), 32'(v.sel));
    checkOutput("NewPC", bus.NewPC, v.npc);
    checkOutput("flush", 32'(bus.flush), 32'(v.fl));
  endtask

  initial begin
    reset = 1'b0; start = 1'b0; stall = 1'b0; redirect_valid = 1'b0;
    redirect_pc = '0; instruction = NOP;

    //               rst st sl rd rpc     instr fe sel npc     fl run hlt chk cnt cs
    tbl.push_back(mk(0, 0, 0, 0, 32'h0,  NOP, 0, 0, 32'h0,  0, 0, 0, 1, 0, 0));
    tbl.push_back(mk(0, 1, 0, 0, 32'h0,  NOP, 0, 0, 32'h0,  0, 0, 0, 1, 0, 0));
    tbl.push_back(mk(1, 0, 0, 0, 32'h0,  NOP, 0, 0, 32'h0,  0, 0, 0, 1, 0, 0));
    tbl.push_back(mk(1, 1, 0, 0, 32'h0,  NOP, 1, 1, 32'h0,  1, 1, 0, 1, 0, 0));
    tbl.push_back(mk(1, 0, 0, 0, 32'h0,  NOP, 1, 0, 32'h0,  0, 1, 0, 1, 1, 1));
    tbl.push_back(mk(1, 1, 0, 0, 32'h0,  NOP, 1, 0, 32'h0,  0, 1, 0, 1, 2, 2));
    tbl.push_back(mk(1, 0, 0, 0, 32'h0,  NOP, 1, 0, 32'h0,  0, 1, 0, 1, 3, 3));
    tbl.push_back(mk(1, 0, 0, 0, 32'h0,  NOP, 1, 0, 32'h0,  0, 1, 0, 1, 4, 3));
    tbl.push_back(mk(1, 0, 0, 0, 32'h0,  NOP, 1, 0, 32'h0,  0, 1, 0, 1, 5, 3));
    tbl.push_back(mk(1, 0, 0, 0, 32'h0,  NOP, 1, 0, 32'h0,  0, 1, 0, 1, 6, 3));
    tbl.push_back(mk(1, 0, 1, 0, 32'h0,  NOP, 0, 0, 32'h0,  0, 1, 0, 1, 6, 3));
    tbl.push_back(mk(1, 0, 1, 0, 32'h0,  NOP, 0, 0, 32'h0,  0, 1, 0, 1, 6, 3));
    tbl.push_back(mk(1, 0, 1, 0, 32'h0,  NOP, 0, 0, 32'h0,  0, 1, 0, 1, 6, 3));
    tbl.push_back(mk(1, 0, 0, 0, 32'h0,  NOP, 1, 0, 32'h0,  0, 1, 0, 1, 7, 3));
    tbl.push_back(mk(1, 0, 1, 1, 32'h40, NOP, 1, 1, 32'h40, 1, 1, 0, 1, 8, 3));
    tbl.push_back(mk(1, 0, 0, 1, 32'h80, HLT, 1, 1, 32'h80, 1, 1, 0, 1, 9, 3));
    tbl.push_back(mk(1, 0, 1, 0, 32'h0,  HLT, 0, 0, 32'h0,  0, 1, 0, 1, 9, 3));
    tbl.push_back(mk(1, 0, 0, 0, 32'h0,  HLT, 0, 0, 32'h0,  1, 0, 0, 1, 9, 3));
    tbl.push_back(mk(1, 1, 1, 0, 32'h0,  HLT, 0, 0, 32'h0,  1, 0, 0, 1, 9, 3));
    tbl.push_back(mk(1, 0, 0, 0, 32'h0,  HLT, 0, 0, 32'h0,  1, 0, 0, 1, 9, 3));
    tbl.push_back(mk(1, 0, 0, 0, 32'h0,  HLT, 0, 0, 32'h0,  1, 0, 0, 1, 9, 3));
    tbl.push_back(mk(1, 0, 0, 0, 32'h0,  HLT, 0, 0, 32'h0,  1, 0, 1, 1, 9, 3));
    tbl.push_back(mk(1, 0, 1, 1, 32'h20, HLT, 0, 0, 32'h0,  0, 0, 1, 1, 9, 3));
    tbl.push_back(mk(1, 1, 0, 0, 32'h0,  NOP, 1, 1, 32'h0,  1, 1, 0, 1, 0, 0));
    tbl.push_back(mk(1, 0, 0, 0, 32'h0,  NOP, 1, 0, 32'h0,  0, 1, 0, 1, 1, 1));

    for (int i = 0; i < tbl.size(); i++) applyStimulus(tbl[i]);

    // Halt cancelled by a redirect in the second DRAIN cycle.
    applyStimulus(mk(1, 0, 0, 0, 32'h0,  HLT, 0, 0, 32'h0,  1, 0, 0, 1, 1, 1));
    applyStimulus(mk(1, 0, 0, 0, 32'h0,  HLT, 0, 0, 32'h0,  1, 0, 0, 1, 1, 1));
    applyStimulus(mk(1, 0, 0, 1, 32'h10, HLT, 1, 1, 32'h10, 1, 1, 0, 0, 0, 0));
    applyStimulus(mk(1, 0, 0, 0, 32'h0,  NOP, 1, 0, 32'h0,  0, 1, 0, 0, 0, 0));

    // Reset arriving mid-DRAIN suppresses the flush and returns to IDLE.
    applyStimulus(mk(1, 0, 0, 0, 32'h0,  HLT, 0, 0, 32'h0,  1, 0, 0, 0, 0, 0));
    applyStimulus(mk(1, 0, 0, 0, 32'h0,  HLT, 0, 0, 32'h0,  1, 0, 0, 0, 0, 0));
    applyStimulus(mk(0, 1, 0, 1, 32'h44, HLT, 0, 0, 32'h0,  0, 0, 0, 1, 0, 0));
    applyStimulus(mk(1, 0, 0, 1, 32'h44, HLT, 0, 0, 32'h0,  0, 0, 0, 1, 0, 0));

    @(negedge clock);
    checkRegistered();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
